// File: rtl/qtcore_scan_sequencer.sv
// Scan-chain program/run/readback sequencer for the accumulator microcontroller core.
// Build option: define QTCORE_SEQ_TIMEOUT_EN to add the RUN watchdog (RUN_TIMEOUT cycles).
module qtcore_scan_sequencer #(
   parameter int unsigned CHAIN_BYTES = 22,
   parameter int unsigned RUN_TIMEOUT = 4096
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic [7:0] i_load_data,
   input  logic       i_load_valid,
   output logic       o_load_ready,
   output logic [7:0] o_rd_data,
   output logic       o_rd_valid,
   input  logic       i_rd_ready,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_timed_out,
   output logic       o_scan_enable,
   output logic       o_scan_in,
   input  logic       i_scan_out,
   output logic       o_proc_en,
   input  logic       i_halt
);
   localparam int unsigned BCW = $clog2(CHAIN_BYTES + 1);
   localparam logic [BCW-1:0] LAST_BYTE = BCW'(CHAIN_BYTES - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_READ, S_DONE} state_t;

   state_t         r_state;
   logic [BCW-1:0] r_byte_cnt;
   logic [2:0]     r_bit_cnt;
   logic [7:0]     r_sr;
   logic [6:0]     r_rd_sr;
   logic [7:0]     r_rd_data;
   logic           r_first_run;
   logic           r_scan_enable;
   logic           r_scan_in;
   logic           r_proc_en;
   logic           r_busy;
   logic           r_done;
   logic           r_rd_valid;
   logic           w_halt_now;
   logic           w_expire;

   // A halt still asserted from a previous run must not end this one on its first cycle.
   assign w_halt_now = (r_state == S_RUN) && !r_first_run && i_halt;

`ifdef QTCORE_SEQ_TIMEOUT_EN
   localparam int unsigned RCW = $clog2(RUN_TIMEOUT + 1);
   localparam logic [RCW-1:0] LAST_RUN = RCW'(RUN_TIMEOUT - 1);

   logic [RCW-1:0] r_run_cnt;
   logic           r_timed_out;

   assign w_expire = (r_state == S_RUN) && (r_run_cnt == LAST_RUN);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_run_cnt   <= '0;
         r_timed_out <= 1'b0;
      end else begin
         r_run_cnt <= (r_state == S_RUN) ? r_run_cnt + 1'b1 : '0;
         if (r_state == S_IDLE && i_start)
            r_timed_out <= 1'b0;
         else if (w_expire && !w_halt_now)
            r_timed_out <= 1'b1;
      end
   end

   assign o_timed_out = r_timed_out;
`else
   assign w_expire    = 1'b0;
   assign o_timed_out = 1'b0;
   // RUN_TIMEOUT carries no meaning without the watchdog.
   if (RUN_TIMEOUT == 0) begin : g_no_watchdog
   end
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_byte_cnt    <= '0;
         r_bit_cnt     <= '0;
         r_sr          <= '0;
         r_rd_sr       <= '0;
         r_rd_data     <= '0;
         r_first_run   <= 1'b0;
         r_scan_enable <= 1'b0;
         r_scan_in     <= 1'b0;
         r_proc_en     <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_rd_valid    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state    <= S_LOAD;
                  r_busy     <= 1'b1;
                  r_byte_cnt <= '0;
                  r_bit_cnt  <= '0;
               end
            end
            S_LOAD: begin
               // scan_enable doubles as the "shifter busy" flag while loading.
               if (!r_scan_enable) begin
                  if (i_load_valid) begin
                     r_scan_enable <= 1'b1;
                     r_scan_in     <= i_load_data[7];
                     r_sr          <= {i_load_data[6:0], 1'b0};
                     r_bit_cnt     <= '0;
                  end
               end else if (r_bit_cnt == 3'd7) begin
                  r_scan_enable <= 1'b0;
                  r_scan_in     <= 1'b0;
                  if (r_byte_cnt == LAST_BYTE) begin
                     r_state     <= S_RUN;
                     r_byte_cnt  <= '0;
                     r_proc_en   <= 1'b1;
                     r_first_run <= 1'b1;
                  end else begin
                     r_byte_cnt <= r_byte_cnt + 1'b1;
                  end
               end else begin
                  r_scan_in <= r_sr[7];
                  r_sr      <= {r_sr[6:0], 1'b0};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
               end
            end
            S_RUN: begin
               r_first_run <= 1'b0;
               if (w_halt_now || w_expire) begin
                  r_proc_en     <= 1'b0;
                  r_state       <= S_READ;
                  r_scan_enable <= 1'b1;
                  r_bit_cnt     <= '0;
               end
            end
            S_READ: begin
               if (r_scan_enable) begin
                  r_rd_sr   <= {r_rd_sr[5:0], i_scan_out};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     r_scan_enable <= 1'b0;
                     r_rd_data     <= {r_rd_sr, i_scan_out};
                     r_rd_valid    <= 1'b1;
                  end
               end else if (r_rd_valid && i_rd_ready) begin
                  r_rd_valid <= 1'b0;
                  if (r_byte_cnt == LAST_BYTE) begin
                     r_state    <= S_DONE;
                     r_done     <= 1'b1;
                     r_byte_cnt <= '0;
                  end else begin
                     r_byte_cnt    <= r_byte_cnt + 1'b1;
                     r_scan_enable <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_load_ready  = (r_state == S_LOAD) && !r_scan_enable;
   // Readback recirculates the chain through itself so its contents survive the dump.
   assign o_scan_in     = (r_state == S_READ) ? i_scan_out : r_scan_in;
   assign o_scan_enable = r_scan_enable;
   assign o_proc_en     = r_proc_en;
   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_rd_data     = r_rd_data;
   assign o_rd_valid    = r_rd_valid;
endmodule

// File: tb/tb_qtcore_scan_sequencer.sv
// Directed bench for qtcore_scan_sequencer: models the core scan chain and halt pin,
// scoreboards loaded bytes against readback.
module tb_qtcore_scan_sequencer;
   localparam int N  = 22;
   localparam int NB = 8 * N;

   logic       clk = 1'b0, rst = 1'b1, start = 1'b0, load_valid = 1'b0, rd_ready = 1'b0, halt = 1'b0;
   logic [7:0] load_data = 8'h00;
   logic       load_ready, rd_valid, busy, done, timed_out, scan_enable, scan_in, scan_out, proc_en;
   logic [7:0] rd_data;

   logic [NB-1:0] chain = '0;
   logic [7:0]    img [N];
   logic [7:0]    sb [$];
   logic          bitlog [$];
   logic          log_en = 1'b0;
   int            se_cnt = 0, pe_cnt = 0, done_cnt = 0;
   int            pe_mark = 0;
   int            checks = 0, failures = 0;

   qtcore_scan_sequencer #(.CHAIN_BYTES(N), .RUN_TIMEOUT(4096)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start),
      .i_load_data(load_data), .i_load_valid(load_valid), .o_load_ready(load_ready),
      .o_rd_data(rd_data), .o_rd_valid(rd_valid), .i_rd_ready(rd_ready),
      .o_busy(busy), .o_done(done), .o_timed_out(timed_out),
      .o_scan_enable(scan_enable), .o_scan_in(scan_in), .i_scan_out(scan_out),
      .o_proc_en(proc_en), .i_halt(halt)
   );

   always #5 clk = ~clk;

   // Core model: chain shifts toward the MSB, scan_out is the MSB.
   assign scan_out = chain[NB-1];
   always @(posedge clk) begin
      if (scan_enable === 1'b1) chain <= {chain[NB-2:0], scan_in};
      se_cnt   <= se_cnt + ((scan_enable === 1'b1) ? 1 : 0);
      pe_cnt   <= pe_cnt + ((proc_en === 1'b1) ? 1 : 0);
      done_cnt <= done_cnt + ((done === 1'b1) ? 1 : 0);
      if (log_en && scan_enable === 1'b1) bitlog.push_back(scan_in);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NB-1:0] img_chain();
      logic [NB-1:0] v;
      v = '0;
      for (int k = 0; k < N; k++) v[NB-1-8*k -: 8] = img[k];
      return v;
   endfunction

   // Starts a sequence and streams img with load_valid held high; abort_bits>0 stops early.
   task automatic load_image(input int abort_bits);
      int idx, t, se0;
      idx = 0;
      t   = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("busy_in_load", busy, 1);
      se0 = se_cnt;
      while (idx < N && t < 400 && !(abort_bits > 0 && se_cnt - se0 >= abort_bits)) begin
         load_valid = 1'b1;
         load_data  = img[idx];
         if (load_ready === 1'b1) begin
            sb.push_back(img[idx]);
            idx++;
         end
         @(negedge clk);
         t++;
      end
      load_valid = 1'b0;
      if (abort_bits == 0) check("load_handshakes", idx, N);
   endtask

   task automatic wait_run_entry();
      int t;
      t = 0;
      while (proc_en !== 1'b1 && t < 40) begin @(negedge clk); t++; end
      check("run_entry", proc_en, 1);
      pe_mark = pe_cnt;
   endtask

   // Entered mid first RUN cycle with halt already high.
   task automatic halt_after_10();
      @(negedge clk);
      check("stale_halt_ignored", proc_en, 1);
      halt = 1'b0;
      repeat (8) @(negedge clk);
      halt = 1'b1;
      @(negedge clk);
      halt = 1'b0;
      check("run_cycles", pe_cnt - pe_mark, 10);
      check("read_after_halt", {proc_en, scan_enable}, 2'b01);
   endtask

   task automatic readback(input int stall_k);
      logic [7:0] exp;
      logic       bad;
      int         t, dn0;
      dn0 = done_cnt;
      for (int k = 0; k < N; k++) begin
         rd_ready = (k != stall_k);
         t = 0;
         while (rd_valid !== 1'b1 && t < 40) begin @(negedge clk); t++; end
         if (sb.size() > 0) exp = sb.pop_front();
         else exp = 8'hxx;
         check($sformatf("rd_data[%0d]", k), {rd_valid, rd_data}, {1'b1, exp});
         if (k == stall_k) begin
            bad = 1'b0;
            repeat (4) begin
               @(negedge clk);
               if (scan_enable !== 1'b0 || rd_valid !== 1'b1 || rd_data !== exp) bad = 1'b1;
            end
            check("stall_hold", bad, 0);
            rd_ready = 1'b1;
         end
         @(negedge clk);
      end
      rd_ready = 1'b0;
      check("done_pulse", {done, busy}, 2'b11);
      @(negedge clk);
      check("idle_after_done", {done, busy}, 2'b00);
      check("done_count", done_cnt - dn0, 1);
      check("chain_preserved", chain === img_chain(), 1);
   endtask

   initial begin
      logic [7:0] b0, b21;
      int         se0;

      // 1: reset, load_valid outside LOAD ignored, reset again mid-idle
      load_valid = 1'b1;
      load_data  = 8'hFF;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_load_ready", {load_ready, busy}, 2'b00);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_outputs", {load_ready, rd_data, rd_valid, busy, done, timed_out,
                              scan_enable, scan_in, proc_en}, 16'h0000);
      rst = 1'b0;
      load_valid = 1'b0;

      // 2/3/4: incrementing image, stale halt, halt after 10, stalled readback
      for (int k = 0; k < N; k++) img[k] = 8'(k);
      bitlog.delete();
      log_en = 1'b1;
      se0 = se_cnt;
      load_image(0);
      halt = 1'b1;
      wait_run_entry();
      log_en = 1'b0;
      check("load_shift_cycles", se_cnt - se0, NB);
      check("load_bits_logged", bitlog.size(), NB);
      b0 = 8'h00;
      b21 = 8'h00;
      for (int i = 0; i < 8; i++) begin
         b0  = {b0[6:0], bitlog[i]};
         b21 = {b21[6:0], bitlog[8*(N-1)+i]};
      end
      check("first_byte_bits", b0, 8'h00);
      check("last_byte_bits", b21, 8'h15);
      check("chain_after_load", chain === img_chain(), 1);
      halt_after_10();
      check("no_timeout_on_halt", timed_out, 0);
      readback(3);

      // 5: halt never asserted
      for (int k = 0; k < N; k++) img[k] = 8'hA5 ^ 8'(k * 13);
      load_image(0);
      wait_run_entry();
`ifdef QTCORE_SEQ_TIMEOUT_EN
      begin
         int t;
         t = 0;
         while (proc_en === 1'b1 && t < 5000) begin @(negedge clk); t++; end
      end
      check("watchdog_run_cycles", pe_cnt - pe_mark, 4096);
      check("timed_out_set", timed_out, 1);
      readback(-1);
      check("timed_out_sticky", timed_out, 1);
`else
      repeat (10000) @(negedge clk);
      check("no_watchdog_proc_en", proc_en, 1);
      check("no_watchdog_timed_out", timed_out, 0);
      halt = 1'b1;
      @(negedge clk);
      halt = 1'b0;
      check("halt_after_long_run", {proc_en, scan_enable}, 2'b01);
      readback(-1);
`endif

      // 6: reset 37 bits into a load, then a clean reload
      for (int k = 0; k < N; k++) img[k] = 8'h3C + 8'(k * 9);
      load_image(37);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_outputs", {scan_enable, busy, load_ready, proc_en}, 4'b0000);
      sb.delete();
      load_image(0);
      check("timed_out_cleared", timed_out, 0);
      halt = 1'b1;
      wait_run_entry();
      check("chain_after_reload", chain === img_chain(), 1);
      halt_after_10();
      readback(-1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end
endmodule
